// File: rtl/sec_mon_pkg.sv
// rtl/sec_mon_pkg.sv - shared state encoding and constants for the security monitor link checker
package sec_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_ALARM = 2'd3
    } sec_state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [7:0]  ERR_CNT_MAX  = 8'hFF;

endpackage

// File: rtl/sec_lfsr.sv
// rtl/sec_lfsr.sv - Galois LFSR stream generator with load, advance and zero-seed substitution
// Ports: clk/rst (sync, active-high), load_i (reload seed), adv_i (step one bit),
//        next_bit_o (bit 0 of the value the register holds after the coming edge).
module sec_lfsr
    import sec_mon_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic adv_i,
    output logic next_bit_o
);

    // An all-zero Galois LFSR is stuck forever, so a zero seed is replaced by 1.
    localparam logic [LFSR_W-1:0] LOAD_VAL = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(LFSR_TAPS);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LOAD_VAL;
        end else if (adv_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign next_bit_o = lfsr_d[0];

endmodule

// File: rtl/sec_link_checker.sv
// rtl/sec_link_checker.sv - loopback tamper detector comparing a returned PRBS stream against its own history
// Ports: wb_clk_i/wb_rst_i (sync, active-high), en_i (run), clr_i (clear pulse),
//        lat_i (loop latency in bits), thresh_i (consecutive mismatches to alarm),
//        rx_i (async returned line), tx_o (transmitted line), alarm_o (sticky),
//        err_cnt_o (saturating mismatch total), state_o (FSM state).
module sec_link_checker
    import sec_mon_pkg::*;
#(
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(DEFAULT_SEED),
    parameter int                BIT_DIV = 8,
    parameter int                HIST_D  = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [1:0] lat_i,
    input  logic [3:0] thresh_i,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       alarm_o,
    output logic [7:0] err_cnt_o,
    output logic [1:0] state_o
);

    localparam int            TW       = $clog2(BIT_DIV);
    localparam int            AW       = $clog2(HIST_D + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(BIT_DIV - 1);
    localparam logic [TW-1:0] T_SAMP   = TW'(BIT_DIV / 2);
    localparam logic [AW-1:0] ARM_LAST = AW'(HIST_D - 1);

    sec_state_e        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [AW-1:0]     arm_cnt_q, arm_cnt_d;
    logic [HIST_D-1:0] hist_q, hist_d;
    logic [3:0]        cons_q, cons_d;
    logic [7:0]        err_q, err_d;
    logic              alarm_q, alarm_d;
    logic              tx_q, tx_d;
    logic              rx_meta_q, rx_sync_q;

    logic       bit_bnd, samp_pt, rx_bad, cmp_en;
    logic       lfsr_load, lfsr_bit;
    logic [3:0] thr;

    assign bit_bnd = (state_q != ST_IDLE) && (timer_q == T_LAST);
    assign samp_pt = (state_q != ST_IDLE) && (timer_q == T_SAMP);
    assign rx_bad  = rx_sync_q != hist_q[lat_i];
    assign thr     = (thresh_i == 4'd0) ? 4'd1 : thresh_i;
    // With en_i low in RUN the checker is leaving; ALARM keeps counting regardless.
    assign cmp_en  = samp_pt && (((state_q == ST_RUN) && en_i) || (state_q == ST_ALARM));

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        cons_d    = cons_q;
        err_d     = err_q;
        alarm_d   = alarm_q;

        if (clr_i) begin
            cons_d  = 4'd0;
            err_d   = 8'd0;
            alarm_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (bit_bnd) begin
                    if (arm_cnt_q == ARM_LAST) state_d = ST_RUN;
                    arm_cnt_d = arm_cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (!en_i) state_d = ST_IDLE;
            end
            ST_ALARM: begin
                if (clr_i) state_d = en_i ? ST_ARM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Evaluated after the clear so a simultaneous alarm condition wins and
        // the counters restart from the cleared value.
        if (cmp_en) begin
            if (rx_bad) begin
                if (err_d != ERR_CNT_MAX) err_d = err_d + 8'd1;
                if (cons_d != 4'hF) cons_d = cons_d + 4'd1;
                if (cons_d >= thr) begin
                    state_d = ST_ALARM;
                    alarm_d = 1'b1;
                end
            end else begin
                cons_d = 4'd0;
            end
        end

        if (lfsr_load) arm_cnt_d = '0;
    end

    assign lfsr_load = (state_d == ST_ARM) && (state_q != ST_ARM);

    always_comb begin
        timer_d = timer_q;
        if (lfsr_load || (state_d == ST_IDLE) || bit_bnd) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // History holds the bit now on the line in slot 0, so lat_i counts whole
    // bits of loop delay.
    always_comb begin
        hist_d = hist_q;
        if (bit_bnd && !lfsr_load) hist_d = {hist_q[HIST_D-2:0], lfsr_bit};
        tx_d = (state_d == ST_IDLE) ? 1'b1 : lfsr_bit;
    end

    sec_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .load_i     (lfsr_load),
        .adv_i      (bit_bnd),
        .next_bit_o (lfsr_bit)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            arm_cnt_q <= '0;
            hist_q    <= '0;
            cons_q    <= 4'd0;
            err_q     <= 8'd0;
            alarm_q   <= 1'b0;
            tx_q      <= 1'b1;
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            arm_cnt_q <= arm_cnt_d;
            hist_q    <= hist_d;
            cons_q    <= cons_d;
            err_q     <= err_d;
            alarm_q   <= alarm_d;
            tx_q      <= tx_d;
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tx_o      = tx_q;
    assign alarm_o   = alarm_q;
    assign err_cnt_o = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sec_link_checker.sv
// tb/tb_sec_link_checker.sv - directed self-checking bench for sec_link_checker
module tb_sec_link_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] lat = 2'd0;
    logic [3:0] thresh = 4'd0;
    logic       rx_i;
    logic       tx_o, alarm_o;
    logic [7:0] err_cnt_o;
    logic [1:0] state_o;

    logic        rx_force = 1'b0;
    logic        rx_val = 1'b0;
    int          dly = 8;
    logic [31:0] dl = '1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_q[$];
    bit          ref_bits [0:1023];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) dl <= {dl[30:0], tx_o};
    assign rx_i = rx_force ? rx_val : dl[dly];

    sec_link_checker dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .en_i      (en),
        .clr_i     (clr),
        .lat_i     (lat),
        .thresh_i  (thresh),
        .rx_i      (rx_i),
        .tx_o      (tx_o),
        .alarm_o   (alarm_o),
        .err_cnt_o (err_cnt_o),
        .state_o   (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] l;
        int e0, j, as_c, fp, sat_p, cnt, exp_err, run_len;
        bit exp_alarm;

        l = 16'hACE1;
        for (int i = 0; i < 1024; i++) begin
            ref_bits[i] = l[0];
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        end

        // reset state
        step(3);
        chk("rst_tx", tx_o, 1);
        chk("rst_alarm", alarm_o, 0);
        chk("rst_err", err_cnt_o, 0);
        chk("rst_state", state_o, 0);
        rst = 1'b0;
        step(2);
        chk("idle_hold", state_o, 0);

        // clean loopback, one-bit loop delay
        dly = 8; lat = 2'd1; thresh = 4'd2;
        en = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < 16; i++) exp_q.push_back(ref_bits[i]);
        for (int k = 0; k < 16; k++) begin
            goto(e0 + 8 * k + 4);
            if (k == 0) chk("arm_state", state_o, 1);
            chk("tx_bit", tx_o, exp_q.pop_front());
        end
        goto(e0 + 2000);
        chk("clean_state", state_o, 2);
        chk("clean_err", err_cnt_o, 0);
        chk("clean_alarm", alarm_o, 0);

        // injected attack over two expected-one bits
        j = 250;
        while (!(ref_bits[j] && ref_bits[j + 1])) j++;
        as_c = e0 + 8 * j + 8;
        goto(as_c);
        rx_val = 1'b0; rx_force = 1'b1;
        goto(as_c + 12);
        chk("atk_alarm_pre", alarm_o, 0);
        step(1);
        chk("atk_alarm_edge", alarm_o, 1);
        goto(as_c + 20);
        rx_force = 1'b0;
        goto(as_c + 24);
        chk("atk_alarm_3bit", alarm_o, 1);
        chk("atk_state", state_o, 3);
        goto(as_c + 100);
        chk("atk_alarm_held", alarm_o, 1);
        chk("atk_err", err_cnt_o, 2 + ref_bits[j + 2]);

        // clear from ALARM with en held, then clean re-arm
        clr = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < 8; i++) exp_q.push_back(ref_bits[i]);
        step(1);
        clr = 1'b0;
        chk("clr_alarm", alarm_o, 0);
        chk("clr_err", err_cnt_o, 0);
        chk("clr_state", state_o, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                goto(e0 + 31);
                chk("rearm_arm_end", state_o, 1);
                step(1);
                chk("rearm_run", state_o, 2);
            end
            goto(e0 + 8 * k + 4);
            chk("rearm_tx_bit", tx_o, exp_q.pop_front());
        end
        goto(e0 + 500);
        chk("rearm_err", err_cnt_o, 0);
        chk("rearm_alarm", alarm_o, 0);
        chk("rearm_state", state_o, 2);

        // latency mismatch: two-bit loop, lat 0, threshold 15
        en = 1'b0; dly = 16; lat = 2'd0; thresh = 4'd15;
        step(1);
        clr = 1'b1; en = 1'b1;
        e0 = cyc + 1;
        step(1);
        clr = 1'b0;
        chk("lat_arm_state", state_o, 1);
        chk("lat_clr_err", err_cnt_o, 0);
        exp_err = 0; run_len = 0; exp_alarm = 1'b0;
        for (int p = 4; p <= 80; p++) begin
            if (ref_bits[p] != ref_bits[p - 2]) begin
                exp_err++;
                run_len++;
            end else begin
                run_len = 0;
            end
            if (run_len >= 15) exp_alarm = 1'b1;
        end
        goto(e0 + 8 * 80 + 6);
        chk("lat0_err", err_cnt_o, exp_err);
        chk("lat0_alarm", alarm_o, exp_alarm);
        chk("lat0_state", state_o, exp_alarm ? 3 : 2);

        en = 1'b0; clr = 1'b1; lat = 2'd2;
        step(1);
        clr = 1'b0; en = 1'b1;
        e0 = cyc + 1;
        goto(e0 + 600);
        chk("lat2_err", err_cnt_o, 0);
        chk("lat2_alarm", alarm_o, 0);
        chk("lat2_state", state_o, 2);

        // reset mid-RUN once err_cnt reaches 5
        en = 1'b0; clr = 1'b1; lat = 2'd0;
        step(1);
        clr = 1'b0; en = 1'b1;
        step(1);
        for (int i = 0; i < 3000 && err_cnt_o != 8'd5; i++) step(1);
        chk("mid_err5", err_cnt_o, 5);
        chk("mid_state", state_o, 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_tx", tx_o, 1);
        chk("mid_rst_err", err_cnt_o, 0);
        chk("mid_rst_alarm", alarm_o, 0);
        chk("mid_rst_state", state_o, 0);
        step(1);
        chk("mid_rst_rearm", state_o, 1);

        // threshold 0 with rx stuck low, then err_cnt saturation
        en = 1'b0; clr = 1'b1;
        step(1);
        clr = 1'b0; rx_val = 1'b0; rx_force = 1'b1; thresh = 4'd0; lat = 2'd0; en = 1'b1;
        e0 = cyc + 1;
        fp = 4;
        while (!ref_bits[fp]) fp++;
        cnt = 0; sat_p = 4;
        for (int p = 4; p < 1000 && cnt < 255; p++) begin
            if (ref_bits[p]) cnt++;
            sat_p = p;
        end
        goto(e0 + 8 * fp + 4);
        chk("thr0_alarm_pre", alarm_o, 0);
        step(1);
        chk("thr0_alarm", alarm_o, 1);
        chk("thr0_err", err_cnt_o, 1);
        chk("thr0_state", state_o, 3);
        goto(e0 + 8 * sat_p + 4);
        chk("sat_pre", err_cnt_o, 254);
        step(1);
        chk("sat_hit", err_cnt_o, 255);
        goto(e0 + 8 * (sat_p + 40) + 6);
        chk("sat_hold", err_cnt_o, 255);
        chk("sat_alarm", alarm_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sec_link_checker.md
Name: sec_link_checker

Overview:
- Loopback tamper detector for the pseudo-secure memory security monitor.
- Transmits a pseudo-random serial stream on one user IO and samples the same stream back on another IO.
- Counts bit mismatches; raises a sticky alarm when the consecutive-mismatch count reaches a programmable threshold.
- Sits directly downstream of the monitor's Wishbone register block: it consumes enable, clear and threshold settings from that block and returns alarm, error count and state for firmware to read.

Parameters:
- LFSR_W, 16: width of the stream generator.
- SEED, 16'hACE1: LFSR load value on arm. A value of 0 is replaced by 16'h0001.
- BIT_DIV, 8: clock cycles per serial bit. Must be at least 4 and even.
- HIST_D, 4: depth of the transmitted-bit history, which is the maximum loop latency in bits.

Ports:
- wb_clk_i, in, 1: system clock.
- wb_rst_i, in, 1: reset, synchronous and active-high.
- en_i, in, 1: run the checker. Level sensitive.
- clr_i, in, 1: one-cycle pulse. Clears alarm_o, err_cnt_o and the consecutive-mismatch counter.
- lat_i, in, 2: loop latency in whole bits. Selects history[lat_i].
- thresh_i, in, 4: consecutive mismatches needed to alarm. A value of 0 is treated as 1.
- rx_i, in, 1: returned serial line. Asynchronous to wb_clk_i.
- tx_o, out, 1: transmitted serial line.
- alarm_o, out, 1: sticky tamper flag.
- err_cnt_o, out, 8: total mismatches, saturating at 8'hFF.
- state_o, out, 2: FSM state for firmware.

Behaviour:
- Reset values: tx_o=1, alarm_o=0, err_cnt_o=0, state_o=IDLE (2'd0). The LFSR, history, consecutive counter and bit timer are all cleared. Reset mid-operation returns everything to these values on the next edge.
- rx_i input path:
  - rx_i passes through a 2-flop synchronizer before use.
  - The lat_i setting does not compensate for the synchronizer; the sample point absorbs it.
- Bit timer:
  - Counts 0..BIT_DIV-1 while the FSM is not IDLE and wraps.
  - Bit boundary is timer==BIT_DIV-1.
  - Sample point is timer==BIT_DIV/2.
- LFSR:
  - Galois, polynomial x^16+x^14+x^13+x^11+1 (tap mask 16'hB400).
  - tx_o = lfsr[0], registered.
  - Advances only at the bit boundary.
- History: on each bit boundary the outgoing bit shifts into history[0] and older bits move toward history[HIST_D-1].
- FSM states:
  - IDLE (0): tx_o=1, no counting. When en_i=1, load SEED, clear the timer, go to ARM.
  - ARM (1): transmits, no comparisons. After HIST_D complete bit periods, go to RUN.
  - RUN (2): at each sample point compare the synchronized rx against history[lat_i].
    - Mismatch: err_cnt_o increments (saturating) and the consecutive counter increments (saturating at 15).
    - Match: consecutive counter clears.
    - When the consecutive counter reaches max(thresh_i,1): go to ALARM and set alarm_o. The transition is registered, so alarm_o rises 1 cycle after the offending sample.
  - ALARM (3): keeps transmitting and keeps counting err_cnt_o. alarm_o stays 1.
- en_i=0 in ARM or RUN: go to IDLE the next cycle. err_cnt_o and alarm_o are held.
- en_i=0 in ALARM: stay in ALARM. Only clr_i or reset leaves ALARM. On clr_i the FSM goes to IDLE if en_i=0, otherwise to ARM with the LFSR reloaded.
- Simultaneous events:
  - clr_i in the same cycle as a mismatch or alarm condition: the alarm wins. alarm_o is set and err_cnt_o is cleared then incremented to 1.
  - clr_i in the same cycle as en_i rising: both take effect.
- lat_i and thresh_i changes take effect at the next sample point. There is no re-arm.

Decomposition:
- Package sec_mon_pkg holds:
  - the state encoding (IDLE/ARM/RUN/ALARM);
  - the LFSR tap mask 16'hB400;
  - the default SEED;
  - the err_cnt saturation value 8'hFF.
- One sub-module, sec_lfsr: Galois LFSR with load, advance and zero-seed substitution. The synchronizer, timer, history, FSM and counters stay in sec_link_checker.

Test Plan:
- Clean loopback:
  - Stimulus: tx_o wired to rx_i through a 1-bit (8-cycle) delay, lat_i=1, thresh_i=2, en_i=1, run for 2000 cycles.
  - Required response: state_o=RUN, err_cnt_o=0, alarm_o=0, and the first 16 tx bits match the LFSR reference model from 16'hACE1.
- Injected attack:
  - Stimulus: same setup, then force rx_i=0 for 20 cycles at cycle 1000.
  - Required response: alarm_o=1 within 3 bit periods of attack start, err_cnt_o between 1 and 3, state_o=3, alarm held after the force is released.
- Threshold and saturation:
  - Stimulus: rx_i tied to 0 constantly, thresh_i=0.
  - Required response: alarm on the first mismatching sample, i.e. the first expected-1 bit after ARM. err_cnt_o saturates at 8'hFF and never wraps.
- Clear and re-arm:
  - Stimulus: from ALARM pulse clr_i with en_i=1, then a clean loopback.
  - Required response: alarm_o=0 and err_cnt_o=0 the next cycle, state ARM for 32 cycles, then RUN with no further errors.
- Latency mismatch:
  - Stimulus: loop delay 2 bits, lat_i=0, thresh_i=15.
  - Required response: err_cnt_o increments, alarm only after 15 consecutive mismatches. With lat_i=2 instead, err_cnt_o=0.
- Reset mid-RUN:
  - Stimulus: assert wb_rst_i for 1 cycle with err_cnt_o=5.
  - Required response: next edge gives tx_o=1, err_cnt_o=0, alarm_o=0, state_o=0. With en_i held at 1, ARM starts on the following cycle.
